mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store controller between the execute stage and the 32-word, word-addressed data memory.
- Accepts one byte-addressed load/store request per transaction through a valid/ready handshake.
- Drives the memory's Ewr/Dir/Din port and captures Dout.
- Synthesises byte and halfword stores by read-modify-write, because the memory only writes whole words. Returns aligned and extended load data, or an error, through a second valid/ready handshake.

Parameters:
- DEPTH, 32: number of 32-bit words in the attached memory. Valid word index is 0..DEPTH-1.
- IDX_W, 5: width of the word index, clog2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range or reserved-size request.
- mem_ewr  out  1  memory write enable (Ewr).
- mem_dir  out  32  memory word index (Dir), zero-extended.
- mem_din  out  32  memory write data (Din).
- mem_dout  in  32  memory read data (Dout), combinational.

Behaviour:
- Memory contract:
  - The memory is level-sensitive and combinational.
  - mem_dir and mem_din are registered and held stable for the whole cycle in which mem_ewr=1.
  - mem_ewr is 1 only in state WRITE, decoded from the state register.
  - mem_dout is ignored whenever mem_ewr=1.
- Reset (async, rst_n=0):
  - state=IDLE.
  - req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0.
  - mem_ewr=0; mem_dir=0; mem_din=0.
  - Reset mid-transaction aborts it. mem_ewr falls immediately and no response is produced.
- States: IDLE, READ, WRITE, RESP.
- req_ready=1 only in IDLE.
- On acceptance (IDLE & req_valid), latch all request fields and check for errors. An error is any of:
  - size=11.
  - half with addr[0]≠0.
  - word with addr[1:0]≠0.
  - addr[31:2] ≥ DEPTH.
- Transitions out of IDLE on acceptance:
  - Error → RESP with resp_err=1. No memory access.
  - Load → READ.
  - Store word → WRITE, with mem_din=wdata.
  - Store byte/half → READ.
- On the accepting edge, load mem_dir with addr[IDX_W+1:2].
- READ: mem_ewr=0. At the end of the cycle, capture mem_dout into rd_word.
  - Load → RESP.
  - Store byte/half → WRITE, with mem_din = rd_word merged with the new lane(s):
    - Byte lane is addr[1:0]; wdata[7:0] goes to bits 8*addr[1:0]+7 : 8*addr[1:0].
    - Half lane is addr[1]; wdata[15:0] goes to bits 16*addr[1]+15 : 16*addr[1].
    - All other bits are preserved.
- WRITE: mem_ewr=1 for exactly one cycle → RESP. mem_din returns to 0 on exit.
- RESP: resp_valid=1, with resp_rdata/resp_err stable. Stay in RESP until resp_ready=1, then go to IDLE.
  - resp_valid drops on that edge.
  - resp_valid never asserts in the same cycle as req_ready.
- Load formatting:
  - Byte = rd_word >> (8*addr[1:0]), low 8 bits kept.
  - Half = rd_word >> (16*addr[1]), low 16 bits kept.
  - Then sign- or zero-extend per req_unsigned. Word loads pass through unchanged.
- Latency from the accepting edge to resp_valid=1:
  - Error: 1 cycle.
  - Load or store word: 2 cycles.
  - Store byte/half: 3 cycles.
- Throughput: at most one transaction in flight. The next request is accepted at the earliest one cycle after the response handshake.
- Request signals are don't-care outside IDLE.

Test Plan:
- Reset with rst_n=0 while in WRITE → mem_ewr=0 immediately; after release req_ready=1, resp_valid=0, mem_dir=0.
- SW addr=0x0000_0010, wdata=0xDEADBEEF → one cycle with mem_ewr=1, mem_dir=4, mem_din=0xDEADBEEF. Then LW 0x10 → resp_rdata=0xDEADBEEF, resp_err=0, 2 cycles after acceptance.
- Word 4 = 0xDEADBEEF; SB addr=0x12, wdata=0x0000_0055 → write cycle mem_din=0xDE55BEEF, response 3 cycles after acceptance.
- Word 4 = 0xDE55BEEF:
  - LB signed at 0x13 → 0xFFFF_FFDE.
  - LBU at 0x13 → 0x0000_00DE.
  - LH signed at 0x10 → 0xFFFF_BEEF.
  - LHU at 0x12 → 0x0000_DE55.
- Each of these → resp_err=1, resp_rdata=0, mem_ewr never asserted, response after 1 cycle:
  - LW at 0x0000_0006 (misaligned).
  - SH at 0x0000_0011 (misaligned).
  - LW at 0x0000_0080 (index 32 ≥ DEPTH).
  - size=11.
- Hold resp_ready=0 for 5 cycles in RESP → resp_valid and resp_rdata stay stable, req_ready=0. Assert resp_ready → IDLE next cycle; a back-to-back request is accepted the cycle after.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store controller between the execute stage and a
// word-addressed data memory. Byte and halfword stores are done by
// read-modify-write because the memory only writes whole words.
module mem_access_unit #(
  parameter int DEPTH = 32,
  parameter int IDX_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_ewr,
  output logic [31:0] mem_dir,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic             accept;
  logic             req_err;
  logic             lat_we;
  logic [1:0]       lat_size;
  logic             lat_uns;
  logic [1:0]       lat_lo;
  logic [15:0]      lat_wdata;
  logic             lat_err;
  logic [31:0]      rd_word;
  logic [IDX_W-1:0] dir_q;
  logic [31:0]      din_q;
  logic [31:0]      merged;
  logic [7:0]       lane_byte;
  logic [15:0]      lane_half;
  logic [31:0]      load_fmt;

  assign accept    = (state == IDLE) && req_valid;
  assign req_ready = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign mem_ewr   = (state == WRITE);
  assign mem_dir   = {{(32-IDX_W){1'b0}}, dir_q};
  assign mem_din   = din_q;

  // Classify the incoming request: reserved size, misalignment or out-of-range word
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'b11:   req_err = 1'b1;
      2'b01:   if (req_addr[0]) req_err = 1'b1;
      2'b10:   if (req_addr[1:0] != 2'b00) req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
    if (req_addr[31:2] >= 30'(DEPTH)) req_err = 1'b1;
  end

  // State register; an asynchronous reset aborts any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode: word stores skip the read, partial stores read first
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err)                 state_nxt = RESP;
          else if (!req_we)            state_nxt = READ;
          else if (req_size == 2'b10)  state_nxt = WRITE;
          else                         state_nxt = READ;
        end
      end
      READ:    state_nxt = lat_we ? WRITE : RESP;
      WRITE:   state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Merge the new byte or halfword lane into the word being read
  always_comb begin
    merged = mem_dout;
    if (lat_size == 2'b00) merged[{lat_lo, 3'b000} +: 8] = lat_wdata[7:0];
    else                   merged[{lat_lo[1], 4'b0000} +: 16] = lat_wdata;
  end

  // Align the captured word and extend it for the requested load size
  always_comb begin
    lane_byte = rd_word[{lat_lo, 3'b000} +: 8];
    lane_half = rd_word[{lat_lo[1], 4'b0000} +: 16];
    case (lat_size)
      2'b00:   load_fmt = lat_uns ? {24'h0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
      2'b01:   load_fmt = lat_uns ? {16'h0, lane_half} : {{16{lane_half[15]}}, lane_half};
      default: load_fmt = rd_word;
    endcase
  end

  // Response data is only meaningful for successful loads while responding
  always_comb begin
    resp_rdata = 32'h0;
    resp_err   = 1'b0;
    if (state == RESP) begin
      resp_err = lat_err;
      if (!lat_err && !lat_we) resp_rdata = load_fmt;
    end
  end

  // Request latching, memory address/data registers and read capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we    <= 1'b0;
      lat_size  <= 2'b00;
      lat_uns   <= 1'b0;
      lat_lo    <= 2'b00;
      lat_wdata <= 16'h0;
      lat_err   <= 1'b0;
      rd_word   <= 32'h0;
      dir_q     <= '0;
      din_q     <= 32'h0;
    end else begin
      if (accept) begin
        lat_we    <= req_we;
        lat_size  <= req_size;
        lat_uns   <= req_unsigned;
        lat_lo    <= req_addr[1:0];
        lat_wdata <= req_wdata[15:0];
        lat_err   <= req_err;
        dir_q     <= req_addr[IDX_W+1:2];
        din_q     <= (!req_err && req_we && req_size == 2'b10) ? req_wdata : 32'h0;
      end
      if (state == READ) begin
        rd_word <= mem_dout;
        if (lat_we) din_q <= merged;
      end
      if (state == WRITE) din_q <= 32'h0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard-driven bench with a behavioural data memory.
module tb_mem_access_unit;

  localparam int DEPTH = 32;
  localparam int IDX_W = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_ewr;
  logic [31:0] mem_dir, mem_din, mem_dout;

  logic [31:0] mem [DEPTH] = '{default: 32'h0};

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic        wr;
    logic [31:0] din;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic        wr;
    logic [31:0] din;
    logic [31:0] dir;
  } exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          ewr;
    logic [31:0] din;
    logic [31:0] dir;
    logic        rdy;
  } obs_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mem_access_unit #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_ewr(mem_ewr),
    .mem_dir(mem_dir), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // Combinational read port and whole-word write port of the data memory
  assign mem_dout = (mem_dir < DEPTH) ? mem[mem_dir[IDX_W-1:0]] : 32'h0;
  always @(posedge clk) if (mem_ewr && mem_dir < DEPTH) mem[mem_dir[IDX_W-1:0]] <= mem_din;

  // Drive one request, push its expectation, then wait for and take the response
  task automatic applyStimulus(input vec_t v, output obs_t o);
    exp_t e;
    bit   got;
    e.rdata = v.rdata; e.err = v.err; e.lat = v.lat; e.wr = v.wr;
    e.din = v.din; e.dir = v.addr >> 2;
    sb.push_back(e);
    o.rdata = 32'h0; o.err = 1'b0; o.lat = 0; o.ewr = 0;
    o.din = 32'h0; o.dir = 32'h0; o.rdy = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    o.rdy = req_ready;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_we = 1'($urandom);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      o.lat++;
      if (mem_ewr) begin o.ewr++; o.din = mem_din; o.dir = mem_dir; end
      if (resp_valid) begin got = 1'b1; break; end
    end
    if (!got) o.lat = 99;
    o.rdata = resp_rdata;
    o.err = resp_err;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=1", req_ready); end
    checks++; if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_resp got=%b/%h/%b exp=0/0/0", resp_valid, resp_rdata, resp_err); end
    checks++; if (mem_ewr !== 1'b0 || mem_dir !== 32'h0 || mem_din !== 32'h0) begin failures++; $display("[TB] FAIL reset_mem got=%b/%h/%h exp=0/0/0", mem_ewr, mem_dir, mem_din); end
    @(negedge clk); rst_n = 1'b1;
    // Start a word store to index 16 and abort it while the write is active
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h40; req_wdata = 32'h12345678;
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk);
    checks++; if (mem_ewr !== 1'b1 || mem_din !== 32'h12345678) begin failures++; $display("[TB] FAIL abort_prewrite got=%b/%h exp=1/12345678", mem_ewr, mem_din); end
    rst_n = 1'b0; #1;
    checks++; if (mem_ewr !== 1'b0) begin failures++; $display("[TB] FAIL abort_ewr got=%b exp=0", mem_ewr); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_dir !== 32'h0) begin failures++; $display("[TB] FAIL abort_release got=%b/%b/%h exp=1/0/0", req_ready, resp_valid, mem_dir); end
    repeat (3) @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("[TB] FAIL abort_noresp got=%b exp=0", resp_valid); end
  endtask

  task automatic test_store_load_word();
    vec_t t[5]; obs_t o; exp_t e;
    t[0] = '{1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1, 32'hDEADBEEF};
    t[1] = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b0, 32'h0};
    t[2] = '{1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0, 2, 1'b0, 32'h0};
    t[3] = '{1'b1, 2'b10, 1'b0, 32'h7C, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1'b1, 32'hCAFEF00D};
    t[4] = '{1'b0, 2'b10, 1'b0, 32'h7C, 32'h0, 32'hCAFEF00D, 1'b0, 2, 1'b0, 32'h0};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(t[i], o);
      e = sb.pop_front();
      checks++; if (o.rdy !== 1'b1) begin failures++; $display("[TB] FAIL word[%0d] ready got=%b exp=1", i, o.rdy); end
      checks++; if (o.rdata !== e.rdata) begin failures++; $display("[TB] FAIL word[%0d] rdata got=%h exp=%h", i, o.rdata, e.rdata); end
      checks++; if (o.err !== e.err) begin failures++; $display("[TB] FAIL word[%0d] err got=%b exp=%b", i, o.err, e.err); end
      checks++; if (o.lat != e.lat) begin failures++; $display("[TB] FAIL word[%0d] latency got=%0d exp=%0d", i, o.lat, e.lat); end
      checks++; if (o.ewr != int'(e.wr)) begin failures++; $display("[TB] FAIL word[%0d] ewr_cycles got=%0d exp=%0d", i, o.ewr, e.wr); end
      if (e.wr) begin
        checks++; if (o.din !== e.din || o.dir !== e.dir) begin failures++; $display("[TB] FAIL word[%0d] write got=%h@%h exp=%h@%h", i, o.din, o.dir, e.din, e.dir); end
      end
    end
  endtask

  task automatic test_store_byte();
    vec_t t[5]; obs_t o; exp_t e;
    t[0] = '{1'b1, 2'b00, 1'b0, 32'h12, 32'h00000055, 32'h0, 1'b0, 3, 1'b1, 32'hDE55BEEF};
    t[1] = '{1'b1, 2'b01, 1'b0, 32'h16, 32'hA5A51234, 32'h0, 1'b0, 3, 1'b1, 32'h12340000};
    t[2] = '{1'b1, 2'b00, 1'b0, 32'h14, 32'hFFFFFF80, 32'h0, 1'b0, 3, 1'b1, 32'h12340080};
    t[3] = '{1'b0, 2'b01, 1'b0, 32'h16, 32'h0, 32'h00001234, 1'b0, 2, 1'b0, 32'h0};
    t[4] = '{1'b0, 2'b00, 1'b0, 32'h14, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1'b0, 32'h0};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(t[i], o);
      e = sb.pop_front();
      checks++; if (o.rdata !== e.rdata) begin failures++; $display("[TB] FAIL part[%0d] rdata got=%h exp=%h", i, o.rdata, e.rdata); end
      checks++; if (o.err !== e.err) begin failures++; $display("[TB] FAIL part[%0d] err got=%b exp=%b", i, o.err, e.err); end
      checks++; if (o.lat != e.lat) begin failures++; $display("[TB] FAIL part[%0d] latency got=%0d exp=%0d", i, o.lat, e.lat); end
      checks++; if (o.ewr != int'(e.wr)) begin failures++; $display("[TB] FAIL part[%0d] ewr_cycles got=%0d exp=%0d", i, o.ewr, e.wr); end
      if (e.wr) begin
        checks++; if (o.din !== e.din || o.dir !== e.dir) begin failures++; $display("[TB] FAIL part[%0d] write got=%h@%h exp=%h@%h", i, o.din, o.dir, e.din, e.dir); end
      end
    end
  endtask

  task automatic test_loads();
    vec_t t[4]; obs_t o; exp_t e;
    t[0] = '{1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 2, 1'b0, 32'h0};
    t[1] = '{1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h000000DE, 1'b0, 2, 1'b0, 32'h0};
    t[2] = '{1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0, 2, 1'b0, 32'h0};
    t[3] = '{1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h0000DE55, 1'b0, 2, 1'b0, 32'h0};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(t[i], o);
      e = sb.pop_front();
      checks++; if (o.rdata !== e.rdata) begin failures++; $display("[TB] FAIL load[%0d] rdata got=%h exp=%h", i, o.rdata, e.rdata); end
      checks++; if (o.err !== e.err || o.ewr != 0) begin failures++; $display("[TB] FAIL load[%0d] err/ewr got=%b/%0d exp=%b/0", i, o.err, o.ewr, e.err); end
      checks++; if (o.lat != e.lat) begin failures++; $display("[TB] FAIL load[%0d] latency got=%0d exp=%0d", i, o.lat, e.lat); end
    end
  endtask

  task automatic test_errors();
    vec_t t[4]; obs_t o; exp_t e;
    t[0] = '{1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 32'h0, 1'b1, 1, 1'b0, 32'h0};
    t[1] = '{1'b1, 2'b01, 1'b0, 32'h11, 32'h1234, 32'h0, 1'b1, 1, 1'b0, 32'h0};
    t[2] = '{1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 32'h0, 1'b1, 1, 1'b0, 32'h0};
    t[3] = '{1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1, 1'b0, 32'h0};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(t[i], o);
      e = sb.pop_front();
      checks++; if (o.rdata !== e.rdata) begin failures++; $display("[TB] FAIL error[%0d] rdata got=%h exp=%h", i, o.rdata, e.rdata); end
      checks++; if (o.err !== e.err) begin failures++; $display("[TB] FAIL error[%0d] err got=%b exp=%b", i, o.err, e.err); end
      checks++; if (o.lat != e.lat) begin failures++; $display("[TB] FAIL error[%0d] latency got=%0d exp=%0d", i, o.lat, e.lat); end
      checks++; if (o.ewr != 0) begin failures++; $display("[TB] FAIL error[%0d] ewr_cycles got=%0d exp=0", i, o.ewr); end
    end
  endtask

  task automatic test_backpressure();
    vec_t v; obs_t o; exp_t e;
    bit got;
    e.rdata = 32'hDE55BEEF; e.err = 1'b0; e.lat = 2; e.wr = 1'b0; e.din = 32'h0; e.dir = 32'h4;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10;
    @(posedge clk); #1; req_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (resp_valid) begin got = 1'b1; break; end
    end
    e = sb.pop_front();
    checks++; if (!got) begin failures++; $display("[TB] FAIL hold_timeout got=no_response exp=response"); end
    for (int c = 0; c < 5; c++) begin
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== e.rdata || req_ready !== 1'b0) begin failures++; $display("[TB] FAIL hold[%0d] got=%b/%h/%b exp=1/%h/0", c, resp_valid, resp_rdata, req_ready, e.rdata); end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("[TB] FAIL release got=%b/%b exp=0/1", resp_valid, req_ready); end
    v = '{1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h0000DE55, 1'b0, 2, 1'b0, 32'h0};
    applyStimulus(v, o);
    e = sb.pop_front();
    checks++; if (o.rdy !== 1'b1 || o.rdata !== e.rdata) begin failures++; $display("[TB] FAIL b2b_after_hold got=%b/%h exp=1/%h", o.rdy, o.rdata, e.rdata); end
    checks++; if (o.lat != e.lat) begin failures++; $display("[TB] FAIL b2b_after_hold latency got=%0d exp=%0d", o.lat, e.lat); end
  endtask

  task automatic test_back_to_back();
    vec_t v; obs_t o; exp_t e;
    logic [31:0] a, d;
    for (int i = 0; i < 6; i++) begin
      a = 32'($urandom_range(6, 31)) << 2;
      d = $urandom;
      v = '{1'b1, 2'b10, 1'b0, a, d, 32'h0, 1'b0, 2, 1'b1, d};
      applyStimulus(v, o);
      e = sb.pop_front();
      checks++; if (o.ewr != 1 || o.din !== e.din || o.dir !== e.dir) begin failures++; $display("[TB] FAIL b2b[%0d] store got=%0d/%h@%h exp=1/%h@%h", i, o.ewr, o.din, o.dir, e.din, e.dir); end
      v = '{1'b0, 2'b10, 1'b0, a, 32'h0, d, 1'b0, 2, 1'b0, 32'h0};
      applyStimulus(v, o);
      e = sb.pop_front();
      checks++; if (o.rdata !== e.rdata || o.lat != e.lat) begin failures++; $display("[TB] FAIL b2b[%0d] load got=%h/%0d exp=%h/%0d", i, o.rdata, o.lat, e.rdata, e.lat); end
    end
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    test_reset();
    test_store_load_word();
    test_store_byte();
    test_loads();
    test_errors();
    test_backpressure();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
